// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: default widths, FSM states and the MEM/WB register layout for the MEM stage
package mem_stage_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_REG_W  = 5;
  typedef enum logic {IDLE, REQ} state_t;
  typedef struct packed {
    logic                  RegWrite;
    logic                  MemtoRead;
    logic [DEF_DATA_W-1:0] ReadData;
    logic [DEF_DATA_W-1:0] ALUResult;
    logic [DEF_REG_W-1:0]  WriteReg;
  } mem_wb_t;
endpackage

// File: rtl/mem_stage_access.sv
// mem_stage_access: MEM stage issuing loads/stores over a req/ack data memory; MEM_MISALIGN_TRAP_EN adds a misaligned-access trap
module mem_stage_access
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite_in,
  input  logic              MemtoRead_in,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [DATA_W-1:0] ALUResult_in,
  input  logic [DATA_W-1:0] WriteData_in,
  input  logic [REG_W-1:0]  WriteReg_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign_err,
`endif
  output logic              RegWrite_out,
  output logic              MemtoRead_out,
  output logic [DATA_W-1:0] ReadData_out,
  output logic [DATA_W-1:0] ALUResult_out,
  output logic [REG_W-1:0]  WriteReg_out
);
  state_t state, stateNext;
  mem_wb_t wb;
  logic ctlRegWrite, ctlMemtoRead;
  logic [DATA_W-1:0] ctlAlu;
  logic [REG_W-1:0] ctlWriteReg;
  logic access, misaligned, issue, retire;
  assign access = MemRead_in | MemWrite_in;
`ifdef MEM_MISALIGN_TRAP_EN
  assign misaligned = access & |ALUResult_in[1:0];
`else
  assign misaligned = 1'b0;
`endif
  assign issue  = state == IDLE && access && !misaligned;
  assign retire = state == REQ && dmem_ack;
  assign dmem_req = state == REQ;
  always_comb begin
    stateNext = issue ? REQ : retire ? IDLE : state;
    mem_stall = issue || (state == REQ && !dmem_ack);
  end
  always_ff @(posedge clk) state <= !reset ? IDLE : stateNext;
  // Stalled edges insert a WB bubble; the ack edge retires the latched access.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
      ctlRegWrite  <= 1'b0;
      ctlMemtoRead <= 1'b0;
      ctlAlu       <= '0;
      ctlWriteReg  <= '0;
      wb           <= '0;
    end else begin
      if (issue) begin
        dmem_we      <= MemWrite_in;
        dmem_addr    <= ALUResult_in[ADDR_W-1:0];
        dmem_wdata   <= WriteData_in;
        ctlRegWrite  <= RegWrite_in;
        ctlMemtoRead <= MemtoRead_in;
        ctlAlu       <= ALUResult_in;
        ctlWriteReg  <= WriteReg_in;
      end
      if (mem_stall)
        wb.RegWrite <= 1'b0;
      else if (retire)
        wb <= '{RegWrite: ctlRegWrite, MemtoRead: ctlMemtoRead, ReadData: dmem_we ? '0 : dmem_rdata,
                ALUResult: ctlAlu, WriteReg: ctlWriteReg};
      else
        wb <= '{RegWrite: RegWrite_in && !misaligned, MemtoRead: MemtoRead_in, ReadData: '0,
                ALUResult: ALUResult_in, WriteReg: WriteReg_in};
    end
  end
`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) misalign_err <= reset && state == IDLE && misaligned;
`endif
  assign RegWrite_out  = wb.RegWrite;
  assign MemtoRead_out = wb.MemtoRead;
  assign ReadData_out  = wb.ReadData;
  assign ALUResult_out = wb.ALUResult;
  assign WriteReg_out  = wb.WriteReg;
endmodule

// File: tb/tb_mem_stage_access.sv
// tb_mem_stage_access: directed and randomized checks of mem_stage_access against a memory/pipeline reference model
module tb_mem_stage_access;
  logic clk = 1'b0;
  logic reset;
  logic RegWrite_in, MemtoRead_in, MemRead_in, MemWrite_in;
  logic [31:0] ALUResult_in, WriteData_in;
  logic [4:0] WriteReg_in;
  logic dmem_req, dmem_we, dmem_ack, mem_stall;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic RegWrite_out, MemtoRead_out;
  logic [31:0] ReadData_out, ALUResult_out;
  logic [4:0] WriteReg_out;
`ifdef MEM_MISALIGN_TRAP_EN
  logic misalign_err;
`endif
  int tests = 0;
  int fails = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  always #5 clk = ~clk;

  mem_stage_access dut (
    .clk(clk), .reset(reset),
    .RegWrite_in(RegWrite_in), .MemtoRead_in(MemtoRead_in), .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .ALUResult_in(ALUResult_in), .WriteData_in(WriteData_in), .WriteReg_in(WriteReg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign_err(misalign_err),
`endif
    .RegWrite_out(RegWrite_out), .MemtoRead_out(MemtoRead_out), .ReadData_out(ReadData_out),
    .ALUResult_out(ALUResult_out), .WriteReg_out(WriteReg_out)
  );

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hA5C3_5A3C;
  endfunction

  task automatic set_in(input logic rw, mtr, mr, mw, input logic [31:0] alu, wd, input logic [4:0] wr);
    RegWrite_in = rw; MemtoRead_in = mtr; MemRead_in = mr; MemWrite_in = mw;
    ALUResult_in = alu; WriteData_in = wd; WriteReg_in = wr;
  endtask

  // One instruction through MEM; entered and left at a negedge. lat = REQ cycle carrying the ack.
  task automatic do_op(input logic rw, mtr, mr, mw, input logic [31:0] alu, wd, input logic [4:0] wr, input int lat);
    logic mem_op;
    logic [31:0] exp_rd;
    mem_op = mr | mw;
    exp_rd = mw ? 32'h0 : mr ? (ref_mem.exists(alu) ? ref_mem[alu] : dflt(alu)) : 32'h0;
    if (mw) ref_mem[alu] = wd;
    set_in(rw, mtr, mr, mw, alu, wd, wr);
    #1;
    tests++; if (mem_stall !== mem_op) begin fails++; $display("FAIL stall_issue got %b exp %b", mem_stall, mem_op); end
    if (mem_op) begin
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL req_high k=%0d got %b exp 1", k, dmem_req); end
        tests++; if (dmem_we !== mw) begin fails++; $display("FAIL we k=%0d got %b exp %b", k, dmem_we, mw); end
        tests++; if (dmem_addr !== alu) begin fails++; $display("FAIL addr k=%0d got %h exp %h", k, dmem_addr, alu); end
        tests++; if (dmem_wdata !== wd) begin fails++; $display("FAIL wdata k=%0d got %h exp %h", k, dmem_wdata, wd); end
        tests++; if (RegWrite_out !== 1'b0) begin fails++; $display("FAIL bubble k=%0d got %b exp 0", k, RegWrite_out); end
        if (k == lat) begin
          dmem_ack = 1'b1;
          if (dmem_we) mem[dmem_addr] = dmem_wdata;
          else dmem_rdata = mem.exists(dmem_addr) ? mem[dmem_addr] : dflt(dmem_addr);
        end
        #1;
        tests++; if (mem_stall !== (k < lat)) begin fails++; $display("FAIL stall_req k=%0d got %b exp %b", k, mem_stall, k < lat); end
      end
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    dmem_rdata = $urandom;
    tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL req_low got %b exp 0", dmem_req); end
    tests++; if (RegWrite_out !== rw) begin fails++; $display("FAIL RegWrite_out got %b exp %b", RegWrite_out, rw); end
    tests++; if (MemtoRead_out !== mtr) begin fails++; $display("FAIL MemtoRead_out got %b exp %b", MemtoRead_out, mtr); end
    tests++; if (ReadData_out !== exp_rd) begin fails++; $display("FAIL ReadData_out got %h exp %h", ReadData_out, exp_rd); end
    tests++; if (ALUResult_out !== alu) begin fails++; $display("FAIL ALUResult_out got %h exp %h", ALUResult_out, alu); end
    tests++; if (WriteReg_out !== wr) begin fails++; $display("FAIL WriteReg_out got %0d exp %0d", WriteReg_out, wr); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_in(1, 1, 0, 0, 32'hFFFF_0000, 32'h1, 5'd31);
    repeat (2) @(negedge clk);
    tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %b exp 0", dmem_req); end
    tests++; if (dmem_we !== 1'b0 || dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin fails++; $display("FAIL rst_dmem got we=%b a=%h d=%h exp 0", dmem_we, dmem_addr, dmem_wdata); end
    tests++; if ({RegWrite_out, MemtoRead_out, ReadData_out, ALUResult_out, WriteReg_out} !== '0) begin fails++; $display("FAIL rst_outs got rw=%b alu=%h wr=%0d exp 0", RegWrite_out, ALUResult_out, WriteReg_out); end
    reset = 1'b1;
  endtask

  task automatic test_alu_op();
    do_op(1, 0, 0, 0, 32'h0000_00A5, 32'h0, 5'd7, 0);
  endtask

  task automatic test_load_slow();
    mem[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100] = 32'hDEAD_BEEF;
    do_op(1, 1, 1, 0, 32'h100, 32'h0, 5'd5, 3);
  endtask

  task automatic test_store_fast();
    do_op(0, 0, 0, 1, 32'h200, 32'h1234_5678, 5'd0, 1);
  endtask

  task automatic test_read_write_both();
    do_op(1, 0, 1, 1, 32'h40, 32'hCAFE_F00D, 5'd12, 2);
  endtask

  task automatic test_back_to_back();
    do_op(1, 1, 1, 0, 32'h200, 32'h0, 5'd3, 2);
    do_op(0, 0, 0, 1, 32'h204, 32'h0BAD_CAFE, 5'd4, 1);
    do_op(1, 1, 1, 0, 32'h204, 32'h0, 5'd6, 1);
  endtask

  task automatic test_reset_in_req();
    set_in(1, 1, 1, 0, 32'h300, 32'h0, 5'd9);
    @(negedge clk);
    tests++; if (dmem_req !== 1'b1) begin fails++; $display("FAIL rreq_pre got %b exp 1", dmem_req); end
    reset = 1'b0;
    set_in(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    #1;
    tests++; if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin fails++; $display("FAIL rreq_abort got req=%b stall=%b exp 0 0", dmem_req, mem_stall); end
    tests++; if ({RegWrite_out, MemtoRead_out, ReadData_out, ALUResult_out, WriteReg_out} !== '0) begin fails++; $display("FAIL rreq_outs got rw=%b rd=%h alu=%h exp 0", RegWrite_out, ReadData_out, ALUResult_out); end
    reset = 1'b1;
    set_in(1, 0, 0, 0, 32'h55, 32'h0, 5'd3);
    dmem_ack = 1'b1;
    dmem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    dmem_ack = 1'b0;
    tests++; if (dmem_req !== 1'b0) begin fails++; $display("FAIL late_ack_req got %b exp 0", dmem_req); end
    tests++; if (ReadData_out !== 32'h0 || ALUResult_out !== 32'h55 || RegWrite_out !== 1'b1 || WriteReg_out !== 5'd3) begin fails++; $display("FAIL late_ack_outs got rd=%h alu=%h rw=%b wr=%0d exp 0 55 1 3", ReadData_out, ALUResult_out, RegWrite_out, WriteReg_out); end
  endtask

`ifdef MEM_MISALIGN_TRAP_EN
  task automatic test_misalign();
    set_in(1, 1, 1, 0, 32'h102, 32'h0, 5'd8);
    #1;
    tests++; if (mem_stall !== 1'b0) begin fails++; $display("FAIL mis_stall got %b exp 0", mem_stall); end
    @(negedge clk);
    tests++; if (misalign_err !== 1'b1 || RegWrite_out !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL mis_pulse got err=%b rw=%b req=%b exp 1 0 0", misalign_err, RegWrite_out, dmem_req); end
    set_in(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    tests++; if (misalign_err !== 1'b0 || dmem_req !== 1'b0) begin fails++; $display("FAIL mis_once got err=%b req=%b exp 0 0", misalign_err, dmem_req); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      int kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a = 32'h1000 + ($urandom_range(0, 7) << 2);
      case (kind)
        0: do_op(1'($urandom), 1'($urandom), 0, 0, $urandom, $urandom, 5'($urandom), 0);
        1: do_op(1'($urandom), 1'($urandom), 1, 0, a, $urandom, 5'($urandom), $urandom_range(1, 4));
        2: do_op(1'($urandom), 1'($urandom), 0, 1, a, $urandom, 5'($urandom), $urandom_range(1, 4));
        default: do_op(1'($urandom), 1'($urandom), 1, 1, a, $urandom, 5'($urandom), $urandom_range(1, 4));
      endcase
    end
  endtask

  initial begin
    reset = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    set_in(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    test_reset();
    test_alu_op();
    test_load_slow();
    test_store_fast();
    test_read_write_both();
    test_back_to_back();
    test_reset_in_req();
`ifdef MEM_MISALIGN_TRAP_EN
    test_misalign();
`endif
    test_random();
    set_in(0, 0, 0, 0, 32'h0, 32'h0, 5'd0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before bench completed");
    $fatal(1, "timeout");
  end
endmodule
